// File: rtl/key_pio_in_pkg.sv
// key_pio_in_pkg: shared constants for the key/switch input PIO.
//   - Avalon register word addresses.
//   - Capture-edge encodings for the EDGE_TYPE parameter.
//   - Startup counter saturation value.
//   - Helper that turns current/previous debounced values into an edge mask.
package key_pio_in_pkg;

  // Register word addresses.
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Capture-edge selections.
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Startup counter value at which debounce and edge capture take over.
  localparam logic [1:0] STARTUP_DONE = 2'd3;

  // Per-bit edge mask for the selected edge type; bits above the PIO width are
  // zero-extended by the caller and ignored.
  function automatic logic [31:0] detect_edges(input logic [31:0] cur,
                                               input logic [31:0] prev,
                                               input int unsigned edge_type);
    logic [31:0] edges;
    unique case (edge_type)
      EDGE_RISE: edges = cur & ~prev;
      EDGE_FALL: edges = ~cur & prev;
      default:   edges = cur ^ prev;
    endcase
    return edges;
  endfunction

endpackage

// File: rtl/key_pio_in_debounce.sv
// key_pio_debounce: single-bit two-flop synchroniser followed by a stability
// counter. A new synchronised level is accepted only after it has differed from
// the accepted level for DEBOUNCE_CYCLES consecutive cycles.
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   bypass_i  : load the synchronised level directly (startup window)
//   din_i     : asynchronous input pin
//   sync_o    : synchronised level (second flop)
//   stable_o  : debounced level
module key_pio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic bypass_i,
  input  logic din_i,
  output logic sync_o,
  output logic stable_o
);

  // A zero-cycle debounce still needs a legal (unused) counter width.
  localparam int unsigned CntW    = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned CntLast = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;

  logic            meta_q;
  logic            sync_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= din_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (bypass_i || (DEBOUNCE_CYCLES == 0)) begin
      stable_d = sync_q;
    end else if (sync_q != stable_q) begin
      // The cycle that would reach DEBOUNCE_CYCLES accepts the new level.
      if (cnt_q == CntW'(CntLast)) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign sync_o   = sync_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/key_pio_in.sv
// key_pio_in: Avalon-MM slave input PIO for pushbuttons and switches.
// Each input is synchronised and debounced, the selected edge is latched into a
// sticky write-1-to-clear register, and a registered, maskable level interrupt
// is raised.
//   clk, reset_n : clock, asynchronous active-low reset
//   address      : register word (0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAPTURE)
//   chipselect   : slave select; readdata is zero when low
//   write_n      : active-low write strobe
//   writedata    : write data
//   in_port      : asynchronous external inputs
//   readdata     : combinational read data, zero wait states
//   irq          : active-high level interrupt
module key_pio_in
  import key_pio_in_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = EDGE_FALL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [1:0]       startup_q, startup_d;
  logic             startup_done;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clear;
  logic [31:0]      edges_all;
  logic             irq_q, irq_d;
  logic             wr_en;

  assign startup_done = (startup_q == STARTUP_DONE);
  assign wr_en        = chipselect && !write_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    key_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .bypass_i (!startup_done),
      .din_i    (in_port[i]),
      .sync_o   (sync[i]),
      .stable_o (stable[i])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wdata;
    logic unused_edges;
    assign unused_wdata = ^writedata[31:WIDTH];
    assign unused_edges = ^edges_all[31:WIDTH];
  end

  assign edges_all = detect_edges(32'(stable), 32'(stable_dly_q), EDGE_TYPE);
  assign edges     = edges_all[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      startup_q    <= 2'd0;
      stable_dly_q <= '0;
      mask_q       <= '0;
      edge_q       <= '0;
      irq_q        <= 1'b0;
    end else begin
      startup_q    <= startup_d;
      stable_dly_q <= stable_dly_d;
      mask_q       <= mask_d;
      edge_q       <= edge_d;
      irq_q        <= irq_d;
    end
  end

  always_comb begin
    startup_d = startup_done ? startup_q : startup_q + 2'd1;

    // While the debouncer is bypassed the delayed copy tracks the value being
    // loaded, so levels already present at reset release never look like an edge.
    stable_dly_d = startup_done ? stable : sync;

    clear = '0;
    if (wr_en && (address == ADDR_EDGE)) begin
      clear = writedata[WIDTH-1:0];
    end

    // A new edge wins over a simultaneous clear of the same bit.
    edge_d = (edge_q & ~clear) | (startup_done ? edges : '0);

    mask_d = mask_q;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end

    irq_d = |(edge_q & mask_q);
  end

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA: readdata = 32'(stable);
        ADDR_MASK: readdata = 32'(mask_q);
        ADDR_EDGE: readdata = 32'(edge_q);
        default:   readdata = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_key_pio_in.sv
module tb_key_pio_in;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;

  logic         clk;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;
  logic [31:0]  readdata;
  logic         irq;

  int checks;
  int errors;

  key_pio_in #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .EDGE_TYPE       (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: input history queue, per-bit run lengths of
  // disagreement, cycles since reset, and the three software-visible registers.
  logic [W-1:0] m_hist[$];
  int           m_run[W];
  int           m_boot;
  logic [W-1:0] m_stable, m_prev, m_edge, m_mask;
  logic         m_irq;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_boot   = 0;
    m_stable = '0;
    m_prev   = '0;
    m_edge   = '0;
    m_mask   = '0;
    m_irq    = 1'b0;
  endtask

  // Advance the reference by one rising edge using the inputs present at it.
  task automatic model_step();
    logic [W-1:0] seen, fall, clr;
    seen = (m_hist.size() >= 2) ? m_hist[1] : '0;
    fall = (m_boot >= 3) ? (m_prev & ~m_stable) : '0;
    clr  = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    m_irq  = |(m_edge & m_mask);
    m_edge = (m_edge & ~clr) | fall;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_prev = m_stable;
    if (m_boot < 3) begin
      m_stable = seen;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_boot++;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (seen[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] >= D) begin
            m_stable[i] = seen[i];
            m_run[i]    = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_hist.push_front(in_port);
    if (m_hist.size() > 2) void'(m_hist.pop_back());
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_stable);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_edge);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check("rd_model", readdata, exp_rd(a));
    chipselect = 1'b0;
  endtask

  task automatic rd_exp(input logic [1:0] a, input string tag, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] data);
    address    = a;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    bit found;
    checks     = 0;
    errors     = 0;
    clk        = 1'b0;
    reset_n    = 1'b0;
    in_port    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    model_reset();

    // Startup with inputs held high.
    repeat (3) @(negedge clk);
    rd_exp(2'd0, "reset_data", 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    idle(6);
    rd_exp(2'd0, "startup_data", 32'hF);
    rd_exp(2'd3, "startup_edge", 32'h0);

    // Falling edge on bit 0, then unmask.
    in_port = 4'hE;
    idle(10);
    rd_exp(2'd0, "fall_data", 32'hE);
    rd_exp(2'd3, "fall_edge", 32'h1);
    check("fall_irq_masked", 32'(irq), 32'h0);
    wr(2'd2, 32'h1);
    tick();
    check("irq_unmask", 32'(irq), 32'h1);

    // Glitch rejection and minimum accepted pulse.
    in_port = 4'hF;
    idle(10);
    wr(2'd3, 32'hF);
    idle(2);
    in_port = 4'hD;
    idle(3);
    in_port = 4'hF;
    idle(10);
    rd_exp(2'd0, "glitch_data", 32'hF);
    rd_exp(2'd3, "glitch_edge", 32'h0);
    in_port = 4'hD;
    idle(4);
    in_port = 4'hF;
    idle(3);
    rd_exp(2'd0, "pulse_data", 32'hD);
    idle(10);
    rd_exp(2'd0, "pulse_restore", 32'hF);
    rd_exp(2'd3, "pulse_edge", 32'h2);

    // Write-1-to-clear.
    wr(2'd3, 32'hF);
    in_port = 4'hA;
    idle(10);
    rd_exp(2'd3, "w1c_start", 32'h5);
    wr(2'd3, 32'h4);
    rd_exp(2'd3, "w1c_partial", 32'h1);
    wr(2'd3, 32'h1);
    rd_exp(2'd3, "w1c_all", 32'h0);
    check("w1c_irq_hold", 32'(irq), 32'h1);
    tick();
    check("w1c_irq_drop", 32'(irq), 32'h0);

    // Clear and new edge on the same bit in the same cycle.
    in_port = 4'hF;
    idle(10);
    in_port = 4'hE;
    found   = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (m_boot >= 3 && m_prev[0] && !m_stable[0]) begin
        wr(2'd3, 32'h1);
        found = 1'b1;
      end else begin
        tick();
      end
    end
    check("coll_found", 32'(found), 32'h1);
    rd_exp(2'd3, "coll_edge", 32'h1);
    tick();
    check("coll_irq", 32'(irq), 32'h1);

    // Register access rules.
    wr(2'd0, 32'hFFFF_FFFF);
    rd_exp(2'd0, "data_ro", 32'hE);
    rd_exp(2'd1, "rsvd", 32'h0);
    address    = 2'd3;
    chipselect = 1'b0;
    #1;
    check("cs_low", readdata, 32'h0);

    // Randomised traffic against the reference.
    for (int c = 0; c < 400; c++) begin
      int unsigned r;
      if ($urandom_range(0, 7) == 0) in_port = W'($urandom);
      r = $urandom_range(0, 9);
      case (r)
        0:       wr(2'd2, $urandom);
        1:       wr(2'd3, $urandom);
        2:       wr(2'd0, $urandom);
        default: begin
          rd(2'($urandom_range(0, 3)));
          tick();
        end
      endcase
    end

    // Reset in the middle of a debounce window.
    in_port = 4'hF;
    wr(2'd2, 32'hF);
    idle(10);
    in_port = 4'h0;
    idle(3);
    reset_n    = 1'b0;
    chipselect = 1'b1;
    write_n    = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check("midrst_rd", readdata, 32'h0);
    end
    check("midrst_irq", 32'(irq), 32'h0);
    chipselect = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(8);
    rd_exp(2'd0, "rerelease_data", 32'h0);
    rd(2'd2);
    rd(2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_pio_in.md
Name: key_pio_in

Overview:
Avalon-MM slave input PIO. It is the read-side counterpart of the HEX output PIOs: it samples external inputs such as the KEY pushbuttons and SW switches, and passes them through a synchroniser and a debouncer. It captures edges into a sticky register and raises a maskable level interrupt to the Nios II. It sits on the system interconnect beside the output PIOs.

Parameters:
WIDTH, 4, number of input bits (1..32).
DEBOUNCE_CYCLES, 50000, clk cycles an input must be stable before it is accepted (0 = debounce bypassed).
EDGE_TYPE, 1, capture edge: 0 = rising, 1 = falling, 2 = any.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
address  input  2  register word address.
chipselect  input  1  Avalon slave select.
write_n  input  1  active-low write strobe.
writedata  input  32  write data.
in_port  input  WIDTH  asynchronous external inputs.
readdata  output  32  read data, zero wait states, combinational.
irq  output  1  level interrupt, active-high.

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. All registers (sync stages, debounce counters, stable value, irq_mask, edge_capture, startup counter) clear to 0 on reset. Outputs after reset: irq = 0; readdata = 0 whenever chipselect is not a read of a non-zero register.
- Synchroniser: 2-flop chain per bit. sync = second stage. Input-to-sync latency is 2 cycles.
- Debounce, per bit:
  - Counter cnt[i] has width clog2(DEBOUNCE_CYCLES+1).
  - If sync[i] == stable[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments. When cnt[i] == DEBOUNCE_CYCLES-1, stable[i] <= sync[i] and cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never reaches stable.
  - With DEBOUNCE_CYCLES = 0, stable <= sync every cycle.
  - Sync-to-stable latency is DEBOUNCE_CYCLES cycles.
- Startup:
  - A 2-bit startup counter saturates at 3, 3 cycles after reset release.
  - Until saturated, stable <= sync directly, with no debounce and no edge capture. Inputs held high at reset therefore produce no spurious edge.
- Edge detect: stable_d = stable delayed 1 cycle.
  - Rising: stable & ~stable_d.
  - Falling: ~stable & stable_d.
  - Any: stable ^ stable_d.
- Edge capture:
  - edge_capture[i] is set on a detected edge and stays set until cleared.
  - Write to address 3: bits set in writedata[WIDTH-1:0] clear the matching edge_capture bits (write-1-to-clear).
  - If an edge and a clear hit the same bit in the same cycle, the set wins (bit = 1).
- Register map:
  - Read, 0 wait states: readdata = register when chipselect is high, else 0. Unused upper bits read 0.
  - 0 DATA: read-only, {0, stable}. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK: read/write, WIDTH bits. A write loads writedata[WIDTH-1:0].
  - 3 EDGE_CAPTURE: read, or write-1-to-clear.
- Write strobe: a write occurs when chipselect && ~write_n, on the same clk edge.
- irq: registered, irq <= |(edge_capture & irq_mask).
  - irq asserts 1 cycle after the edge_capture bit sets, or after the mask write.
  - irq deasserts 1 cycle after the clear or unmask.
- Reset mid-operation clears everything asynchronously. The startup rule then applies again after release.

Decomposition:
- Shared package: register address constants (ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3) and EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- One natural sub-module: key_pio_debounce, a single-bit synchroniser plus debounce counter, instantiated WIDTH times by generate.
- The top level holds the startup counter, edge detection, registers, read mux and irq.

Test Plan:
- Bench parameters: WIDTH = 4, DEBOUNCE_CYCLES = 4, EDGE_TYPE = 1.
- Startup: reset with in_port = 4'hF, then release → after startup, read address 0 = 32'h0000000F, read address 3 = 0, irq stays 0.
- Falling edge: in_port 4'hF → 4'hE held 10 cycles → DATA = 32'hE, EDGE_CAPTURE = 32'h1. With mask 0, irq = 0. Write address 2 = 32'h1 → irq = 1 one cycle later.
- Glitch: bit 1 goes low for 3 cycles then returns high → DATA is unchanged at 32'hF and EDGE_CAPTURE stays 0. A 4-cycle low pulse is accepted: DATA shows 32'hD for a while and EDGE_CAPTURE bit 1 sets.
- W1C: EDGE_CAPTURE = 32'h5, write address 3 = 32'h4 → reads 32'h1. Then write 32'h1 → reads 0, and irq drops 1 cycle later.
- Collision: a clear write of bit 0 in the same cycle as a new falling edge on bit 0 → EDGE_CAPTURE bit 0 remains 1 and irq stays 1.
- Register access: write address 0 = 32'hFFFFFFFF → DATA is unchanged. Address 1 reads 0. With chipselect = 0, readdata = 0. Assert reset_n low mid-debounce → all registers read 0 and irq = 0 immediately.
